// File: rtl/btb_predictor_nbit.sv
// Branch target buffer with N-bit saturating direction counters, tag check, bulk flush and saturating stats.
// Lookup is combinational. Updates land on the next edge. There is no backpressure: every EX_brn strobe is absorbed.
module btb_predictor_nbit #(
   parameter int PC_BITS  = 5,
   parameter int ENTRIES  = 8,
   parameter int CNT_BITS = 2,
   parameter int STAT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_BITS-1:0] F_pc,
   output logic               F_BP_taken,
   output logic [PC_BITS-1:0] F_BP_target_pc,
   input  logic               EX_brn,
   input  logic [PC_BITS-1:0] EX_pc,
   input  logic [PC_BITS-1:0] EX_target,
   input  logic               EX_true_taken,
   input  logic               EX_BP_taken,
   input  logic               flush,
   output logic [STAT_W-1:0]  stat_branches,
   output logic [STAT_W-1:0]  stat_mispred
);
   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = PC_BITS - IDX_BITS;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
   localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

   logic [ENTRIES-1:0]  r_valid;
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [PC_BITS-1:0]  r_target [ENTRIES];
   logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
   logic [STAT_W-1:0]   r_stat_br;
   logic [STAT_W-1:0]   r_stat_mp;

   logic [IDX_BITS-1:0] w_f_idx;
   logic [TAG_BITS-1:0] w_f_tag;
   logic                w_f_hit;
   logic [IDX_BITS-1:0] w_ex_idx;
   logic [TAG_BITS-1:0] w_ex_tag;
   logic                w_ex_hit;
   logic                w_ex_mispred;

   assign w_f_idx  = F_pc[IDX_BITS-1:0];
   assign w_f_tag  = F_pc[PC_BITS-1:IDX_BITS];
   assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign w_ex_idx = EX_pc[IDX_BITS-1:0];
   assign w_ex_tag = EX_pc[PC_BITS-1:IDX_BITS];
   assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
   assign w_ex_mispred = EX_BP_taken != EX_true_taken;

   // Lookup reads the registered table only, so a same-cycle update is not bypassed.
   assign F_BP_taken     = w_f_hit && r_cnt[w_f_idx][CNT_BITS-1];
   assign F_BP_target_pc = F_BP_taken ? r_target[w_f_idx] : '0;
   assign stat_branches  = r_stat_br;
   assign stat_mispred   = r_stat_mp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_WNT;
         end
      end else if (flush) begin
         r_valid <= '0;
      end else if (EX_brn) begin
         if (w_ex_hit) begin
            if (EX_true_taken) begin
               if (r_cnt[w_ex_idx] != CNT_MAX) r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_BITS'(1);
               r_target[w_ex_idx] <= EX_target;
            end else if (r_cnt[w_ex_idx] != '0) begin
               r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_BITS'(1);
            end
         end else if (EX_true_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= EX_target;
            r_cnt[w_ex_idx]    <= CNT_WT;
         end
      end
   end

   // Statistics ignore flush and hold at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (EX_brn) begin
         if (r_stat_br != '1) r_stat_br <= r_stat_br + STAT_W'(1);
         if (w_ex_mispred && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + STAT_W'(1);
      end
   end
endmodule

// File: tb/tb_btb_predictor_nbit.sv
// Directed bench for btb_predictor_nbit (PC_BITS=5, ENTRIES=8, CNT_BITS=2, STAT_W=4).
// Expected values are queued as each step is driven and popped when the DUT output is sampled.
module tb_btb_predictor_nbit;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] F_pc;
   logic       F_BP_taken;
   logic [4:0] F_BP_target_pc;
   logic       EX_brn;
   logic [4:0] EX_pc;
   logic [4:0] EX_target;
   logic       EX_true_taken;
   logic       EX_BP_taken;
   logic       flush;
   logic [3:0] stat_branches;
   logic [3:0] stat_mispred;

   btb_predictor_nbit #(.PC_BITS(5), .ENTRIES(8), .CNT_BITS(2), .STAT_W(4)) dut (
      .clk(clk), .rst(rst), .F_pc(F_pc), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
      .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_target(EX_target), .EX_true_taken(EX_true_taken),
      .EX_BP_taken(EX_BP_taken), .flush(flush), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic compare(input logic [31:0] obs);
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) n_pass++;
         else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
   endtask

   task automatic lookup(input string t, input logic [4:0] pc, input logic etk, input logic [4:0] etgt);
      F_pc = pc;
      push({t, "_taken"}, {31'd0, etk});
      push({t, "_target"}, {27'd0, etgt});
      #1;
      compare({31'd0, F_BP_taken});
      compare({27'd0, F_BP_target_pc});
   endtask

   task automatic stats(input string t, input int br, input int mp);
      push({t, "_branches"}, br);
      push({t, "_mispred"}, mp);
      compare({28'd0, stat_branches});
      compare({28'd0, stat_mispred});
   endtask

   task automatic upd(input logic [4:0] pc, input logic [4:0] tgt, input logic tk, input logic bp);
      EX_brn = 1'b1;
      EX_pc = pc;
      EX_target = tgt;
      EX_true_taken = tk;
      EX_BP_taken = bp;
      @(posedge clk);
      #1;
      EX_brn = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      F_pc = 5'd3;
      EX_brn = 1'b0;
      EX_pc = '0;
      EX_target = '0;
      EX_true_taken = 1'b0;
      EX_BP_taken = 1'b0;
      flush = 1'b0;

      // Reset state
      #3;
      lookup("t1_reset", 5'd3, 1'b0, 5'd0);
      stats("t1_reset", 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Allocate at pc 5 then train up and down
      upd(5'd5, 5'd17, 1'b1, 1'b0);
      lookup("t2_alloc", 5'd5, 1'b1, 5'd17);
      stats("t2_alloc", 1, 1);
      upd(5'd5, 5'd17, 1'b1, 1'b1);
      lookup("t2_cnt3", 5'd5, 1'b1, 5'd17);
      upd(5'd5, 5'd17, 1'b0, 1'b1);
      lookup("t2_cnt2", 5'd5, 1'b1, 5'd17);
      upd(5'd5, 5'd17, 1'b0, 1'b1);
      lookup("t2_cnt1", 5'd5, 1'b0, 5'd0);
      stats("t2_end", 4, 3);

      // Tag aliasing at index 5
      upd(5'd5, 5'd9, 1'b1, 1'b0);
      lookup("t3_pc5", 5'd5, 1'b1, 5'd9);
      lookup("t3_pc13_miss", 5'd13, 1'b0, 5'd0);
      upd(5'd13, 5'd2, 1'b1, 1'b0);
      lookup("t3_pc13_hit", 5'd13, 1'b1, 5'd2);
      lookup("t3_pc5_evicted", 5'd5, 1'b0, 5'd0);
      stats("t3_end", 6, 5);

      // Same-cycle lookup and update: old contents this cycle, new next cycle
      @(posedge clk);
      #1;
      F_pc = 5'd13;
      EX_brn = 1'b1;
      EX_pc = 5'd13;
      EX_target = 5'd2;
      EX_true_taken = 1'b0;
      EX_BP_taken = 1'b1;
      lookup("t4_same_old", 5'd13, 1'b1, 5'd2);
      @(posedge clk);
      #1;
      EX_brn = 1'b0;
      lookup("t4_same_new", 5'd13, 1'b0, 5'd0);
      upd(5'd2, 5'd30, 1'b1, 1'b1);
      lookup("t4_pc2", 5'd2, 1'b1, 5'd30);
      upd(5'd13, 5'd4, 1'b1, 1'b1);
      lookup("t4_pc13", 5'd13, 1'b1, 5'd4);

      // Flush beats a same-cycle update; statistics still count it
      flush = 1'b1;
      upd(5'd7, 5'd11, 1'b1, 1'b0);
      flush = 1'b0;
      lookup("t4_flush_pc2", 5'd2, 1'b0, 5'd0);
      lookup("t4_flush_pc13", 5'd13, 1'b0, 5'd0);
      lookup("t4_flush_pc7", 5'd7, 1'b0, 5'd0);
      stats("t4_flush", 10, 7);

      // Direction counter saturation at the top and bottom
      for (int i = 0; i < 5; i++) upd(5'd3, 5'd21, 1'b1, 1'b1);
      lookup("t5_cnt_sat_hi", 5'd3, 1'b1, 5'd21);
      stats("t5_br_sat", 15, 7);
      upd(5'd3, 5'd21, 1'b0, 1'b1);
      lookup("t5_cnt_2", 5'd3, 1'b1, 5'd21);
      upd(5'd3, 5'd21, 1'b0, 1'b1);
      lookup("t5_cnt_1", 5'd3, 1'b0, 5'd0);
      upd(5'd3, 5'd21, 1'b0, 1'b0);
      upd(5'd3, 5'd21, 1'b0, 1'b0);
      upd(5'd3, 5'd21, 1'b1, 1'b0);
      lookup("t5_cnt_sat_lo", 5'd3, 1'b0, 5'd0);
      upd(5'd3, 5'd22, 1'b1, 1'b0);
      lookup("t5_cnt_rise", 5'd3, 1'b1, 5'd22);

      // Statistics saturation: 20 mispredicted branches on a non-allocating path
      for (int i = 0; i < 20; i++) upd(5'd0, 5'd0, 1'b0, 1'b1);
      stats("t5_stat_sat", 15, 15);
      lookup("t5_pc0_untouched", 5'd0, 1'b0, 5'd0);

      // Asynchronous reset between edges
      @(posedge clk);
      #2;
      F_pc = 5'd3;
      rst = 1'b0;
      lookup("t6_async", 5'd3, 1'b0, 5'd0);
      stats("t6_async", 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      lookup("t6_post", 5'd3, 1'b0, 5'd0);
      upd(5'd3, 5'd8, 1'b1, 1'b0);
      lookup("t6_first_alloc", 5'd3, 1'b1, 5'd8);
      stats("t6_first", 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
